// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
// Shared definitions for the bit-serial adder:
//   - FSM state encodings (IDLE / RUN / DONE)
//   - cnt_width(): bit counter width for a given operand width,
//     clog2(WIDTH+1)
package serial_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/fulladder.sv
// fulladder
// Single-bit full adder cell.
// Ports:
//   a, b, cin : addend bits and carry in
//   s         : sum bit
//   cout      : carry out
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder
// Bit-serial ripple adder. Operands are captured on a start pulse and fed
// LSB first, one bit pair per clock, through a single fulladder cell; the
// carry is held in a flip-flop between bits.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN (adds the sub port; when sub=1
// the result is a - b, computed as a + ~b + 1, cout=1 meaning no borrow).
//
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset
//   start  : operation request, sampled only in IDLE
//   a, b   : WIDTH-bit operands, captured on the accepting edge
//   cin    : initial carry, captured on the accepting edge
//   sub    : subtract request (only with SERIAL_ADDER_SUB_EN)
//   busy   : high while bits are being processed
//   done   : one-cycle pulse when sum/cout hold a new result
//   sum    : registered result
//   cout   : registered final carry
//
// Handshake: start is accepted on an edge where the block is IDLE (busy=0,
// done=0). Starts while busy or done are dropped, not queued. Exactly WIDTH
// edges after acceptance, sum/cout update and done pulses for one cycle;
// sum/cout otherwise hold the previous result.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] psum_next;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             fa_s;
    logic             fa_cout;
    logic [WIDTH-1:0] b_load;
    logic             cin_load;

    // Operand/carry values captured at the accepting edge. Subtraction is
    // a + ~b + 1, so B is inverted and the carry forced high.
    always_comb begin
        b_load   = b;
        cin_load = cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            b_load   = ~b;
            cin_load = 1'b1;
        end
`endif
    end

    fulladder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // New sum bit enters at the MSB; after WIDTH shifts the first (LSB)
    // result bit has arrived at bit 0.
    always_comb begin
        psum_next            = psum >> 1;
        psum_next[WIDTH-1]   = fa_s;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            psum  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b_load;
                        carry <= cin_load;
                        cnt   <= '0;
                        psum  <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= fa_cout;
                    psum  <= psum_next;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        sum   <= psum_next;
                        cout  <= fa_cout;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [W:0]   exp_q[$];
  logic [W-1:0] last_sum = '0;
  logic         last_cout = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // reference model: plain integer arithmetic
  function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                       input logic cv, input logic sv);
    int r;
    if (sv) r = int'(av) + int'(~bv) + 1;
    else    r = int'(av) + int'(bv) + int'(cv);
    return r[W:0];
  endfunction

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] req);
    total_cnt++;
    if (act !== req) $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    else pass_cnt++;
  endtask

  // driver: launch one operation and follow it to done
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        input logic sv, input int repulse_cyc, input string name);
    int cyc;
    int busy_cnt;
    logic got;
    logic [W:0] e;
    exp_q.push_back(model(av, bv, cv, sv));
    @(negedge clk);
    a = av; b = bv; cin = cv; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub = sv;
`endif
    cyc = 0; busy_cnt = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (cyc == repulse_cyc) begin
        start = 1'b1; a = 8'h80; b = 8'h80; cin = 1'b0;
      end else if (cyc == repulse_cyc + 1) begin
        start = 1'b0;
      end
      chk({name, "_busy_done_overlap"}, {8'h0, busy & done}, 9'h0);
      if (busy) begin
        busy_cnt++;
        chk({name, "_hold"}, {cout, sum}, {last_cout, last_sum});
      end
      if (done) got = 1'b1;
    end
    chk({name, "_done_seen"}, {8'h0, got}, 9'h1);
    chk({name, "_latency"}, 9'(cyc), 9'(W + 1));
    chk({name, "_busy_cycles"}, 9'(busy_cnt), 9'(W));
    e = exp_q.pop_front();
    chk({name, "_result"}, {cout, sum}, e);
    last_cout = e[W];
    last_sum  = e[W-1:0];
    @(negedge clk);
    chk({name, "_idle_after"}, {7'h0, busy, done}, 9'h0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, cout, 6'h0}, 9'h0);
    chk("reset_sum", {1'b0, sum}, 9'h0);
    reset = 1'b0;
    last_sum = '0; last_cout = 1'b0;
  endtask

  task automatic test_basic_add();
    run_op(8'h35, 8'h4A, 1'b0, 1'b0, -5, "basic_add");
    chk("basic_add_const", {cout, sum}, 9'h07F);
  endtask

  task automatic test_result_hold();
    // previous result 0x7F must hold through the whole RUN phase
    run_op(8'h01, 8'h01, 1'b0, 1'b0, -5, "result_hold");
    chk("result_hold_const", {cout, sum}, 9'h002);
  endtask

  task automatic test_carry_ripple();
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, -5, "ripple_ff_01");
    chk("ripple_ff_01_const", {cout, sum}, 9'h100);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, -5, "ripple_ff_ff_c");
    chk("ripple_ff_ff_c_const", {cout, sum}, 9'h1FF);
  endtask

  task automatic test_start_ignored();
    run_op(8'h01, 8'h02, 1'b0, 1'b0, 3, "start_ignored");
    chk("start_ignored_const", {cout, sum}, 9'h003);
  endtask

  task automatic test_mid_reset();
    int cyc;
    @(negedge clk);
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    cyc = 0;
    while (cyc < 3) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
    end
    reset = 1'b1;   // sampled at E4
    @(negedge clk);
    reset = 1'b0;
    chk("mid_reset_flags", {7'h0, busy, done}, 9'h0);
    chk("mid_reset_result", {cout, sum}, 9'h000);
    last_sum = '0; last_cout = 1'b0;
    @(negedge clk);
    chk("mid_reset_stays_idle", {7'h0, busy, done}, 9'h0);
    run_op(8'h0F, 8'h01, 1'b0, 1'b0, -5, "after_reset");
    chk("after_reset_const", {cout, sum}, 9'h010);
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    run_op(8'h10, 8'h01, 1'b0, 1'b1, -5, "sub_10_01");
    chk("sub_10_01_const", {cout, sum}, 9'h10F);
    run_op(8'h01, 8'h02, 1'b1, 1'b1, -5, "sub_01_02");
    chk("sub_01_02_const", {cout, sum}, 9'h0FF);
    run_op(8'h35, 8'h4A, 1'b1, 1'b0, -5, "sub0_add");
    chk("sub0_add_const", {cout, sum}, 9'h080);
  endtask
`endif

  task automatic test_random();
    logic sv;
    for (int i = 0; i < 20; i++) begin
      sv = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sv = 1'($urandom_range(0, 1));
`endif
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), sv, -5, "random");
    end
  endtask

  task automatic test_back_to_back();
    // start held high continuously: one op per W+2 cycles, never overlapped
    int ops;
    int cyc;
    @(negedge clk);
    a = 8'h11; b = 8'h22; cin = 1'b1; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    ops = 0; cyc = 0;
    while (cyc < 3 * (W + 2)) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        ops++;
        chk("b2b_result", {cout, sum}, 9'h034);
        chk("b2b_spacing", 9'(cyc), 9'(ops * (W + 2) - 1));
      end
    end
    start = 1'b0;
    chk("b2b_ops", 9'(ops), 9'd3);
    repeat (W + 3) @(negedge clk);
    last_sum = sum; last_cout = cout;
    if (last_sum === 8'h34) begin end
    last_sum = 8'h34; last_cout = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_result_hold();
    test_carry_ripple();
    test_start_ignored();
    test_mid_reset();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
